sa_controller: RTL
==================

# sa_controller

Sequencing controller for the parametric systolic array (SA) matrix multiplier. The block holds one N×N operand matrix A (west operand) and one N×N operand matrix B (north operand), loaded element-by-element by a host. On `start` it clears the array and drives the skewed A rows into `matrix_W` and the skewed B columns into `matrix_N`. It then waits for the array's `valid`, captures the N×N result and signals `done`.

## Interface

Parameters:
- `N`, default 4: array dimension; also the size of matrices A, B and the result.
- `WDATA`, default 4: operand element width; results are 2*WDATA wide.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `ld_en`  in  1  host element write strobe.
- `ld_sel`  in  1  write target: 0 = A, 1 = B.
- `ld_row`  in  $clog2(N)  zero-based row index.
- `ld_col`  in  $clog2(N)  zero-based column index.
- `ld_data`  in  WDATA  element value.
- `start`  in  1  single-cycle run request.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse when `result` is updated.
- `err`  out  1  sticky timeout flag; exists only under `SA_CTRL_TIMEOUT_EN`.
- `sa_rst_n`  out  1  array reset, active low; drives the SA `rst_n`.
- `sa_matrix_N`  out  WDATA×[1:N]  north-edge feed, indexed by column j.
- `sa_matrix_W`  out  WDATA×[1:N]  west-edge feed, indexed by row i.
- `sa_matrix_out`  in  2*WDATA×[1:N][1:N]  array accumulator outputs.
- `sa_valid`  in  1  array result-valid flag.
- `result`  out  2*WDATA×[1:N][1:N]  registered copy of the product.

## Operation

- FSM states are IDLE, CLEAR, FEED, DRAIN and DONE.
- IDLE:
  - `ld_en` writes `ld_data` into A[ld_row][ld_col] or B[ld_row][ld_col], selected by `ld_sel`.
  - `start` moves the FSM to CLEAR.
  - If `ld_en` and `start` are high in the same cycle, the write is performed and is visible to the run.
- CLEAR: lasts 1 cycle with `sa_rst_n`=0, then moves to FEED with the feed counter t=0.
- FEED: lasts 2N-1 cycles, t = 0 … 2N-2.
  - Row i (1..N): `sa_matrix_W[i]` = A[i-1][t-(i-1)] when 0 ≤ t-(i-1) < N, otherwise 0.
  - Column j (1..N): `sa_matrix_N[j]` = B[t-(j-1)][j-1] under the same window rule, otherwise 0.
  - After t = 2N-2 the FSM moves to DRAIN.
- DRAIN:
  - Both feeds are driven to 0.
  - When `sa_valid`=1 is sampled, `result` ← `sa_matrix_out` and the FSM moves to DONE.
- DONE: lasts 1 cycle with `done`=1, then the FSM returns to IDLE.
- Ignored inputs:
  - `ld_en` is ignored in every state except IDLE; operand storage is frozen during a run.
  - `start` is ignored while `busy`=1.
- Arithmetic: the controller performs no arithmetic. Results are passed through unmodified at 2*WDATA bits, and overflow behaviour belongs to the array.
- `sa_valid` is only observed in DRAIN. A `sa_valid` level in other states has no effect.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `sa_rst_n`=0, feeds 0, `result` all 0. Operand storage is not reset.
- `sa_rst_n`:
  - Registered; it returns to 1 on the first cycle after `rst_n` deasserts.
  - It is 0 only in reset and in CLEAR.
- Run timeline, with `start` sampled at edge 0:
  - Edge 1: CLEAR.
  - Edges 2 … 2N: FEED.
  - Edge 2N+1: DRAIN is entered.
  - `sa_valid` sampled at edge k: `result` and `done`=1 appear at edge k+1, and IDLE follows at edge k+2.
- Back-to-back runs: a `start` asserted in the first IDLE cycle after DONE is accepted.
- Reset mid-run: asserting `rst_n`=0 in any state aborts the run on the next edge. All outputs return to their reset values, `done` is not pulsed and `result` is cleared.

## Configuration

- Macro: `SA_CTRL_TIMEOUT_EN`.
- When defined:
  - A watchdog counts DRAIN cycles.
  - If `sa_valid` is not seen within 3N+4 cycles, the FSM goes to DONE without updating `result` and sets `err`=1.
  - `err` stays set until the next accepted `start` or until reset.
- When undefined: the `err` port and the watchdog are absent, and DRAIN waits indefinitely.

## Test plan

- Reset release: hold `rst_n`=0 for 3 cycles, then release. Required: `busy`=0, `done`=0, `result`=0, `sa_rst_n`=0 during reset and 1 the following cycle.
- Identity product (N=4): load A=I and B[r][c]=r+c, then pulse `start`. Required: CLEAR for exactly 1 cycle, 7 FEED cycles with the correct skew (e.g. t=3: W[4]=A[3][0]=0, N[1]=B[3][0]=3), and `result`[r][c]=r+c with a single `done` pulse.
- Simultaneous load and start: write A[0][0]=5 in the same cycle as `start`, with B=I. Required: `result`[1][1]=5.
- Ignored inputs: pulse `start` and `ld_en` during FEED. Required: no restart, operands unchanged, and the FEED length is still 2N-1 cycles.
- Reset mid-FEED at t=2: required outputs return to reset values next cycle, with no `done` pulse.
- Timeout (`SA_CTRL_TIMEOUT_EN` defined): hold `sa_valid`=0. Required: `done` pulses 3N+4 cycles after DRAIN entry (16 for N=4), `err`=1, `result` unchanged, and `err` clears on the next accepted `start`.

Source files
------------

// File: rtl/sa_controller_if.sv
// Host load/run port and systolic-array side port of sa_controller.
// Optional macro SA_CTRL_TIMEOUT_EN adds the sticky err flag.
interface sa_controller_if #(
    parameter int N     = 4,
    parameter int WDATA = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Handshake: start is accepted only in a cycle where busy=0; done is a one-cycle
    // pulse that marks a result update; sa_valid is observed only while draining.
    logic                            ld_en;
    logic                            ld_sel;
    logic [IW-1:0]                   ld_row;
    logic [IW-1:0]                   ld_col;
    logic [WDATA-1:0]                ld_data;
    logic                            start;
    logic                            busy;
    logic                            done;
`ifdef SA_CTRL_TIMEOUT_EN
    logic                            err;
`endif
    logic                            sa_rst_n;
    logic [1:N][WDATA-1:0]           sa_matrix_N;
    logic [1:N][WDATA-1:0]           sa_matrix_W;
    logic [1:N][1:N][2*WDATA-1:0]    sa_matrix_out;
    logic                            sa_valid;
    logic [1:N][1:N][2*WDATA-1:0]    result;

`ifdef SA_CTRL_TIMEOUT_EN
    modport master (
        output ld_en, ld_sel, ld_row, ld_col, ld_data, start, sa_matrix_out, sa_valid,
        input  busy, done, err, sa_rst_n, sa_matrix_N, sa_matrix_W, result
    );
    modport slave (
        input  ld_en, ld_sel, ld_row, ld_col, ld_data, start, sa_matrix_out, sa_valid,
        output busy, done, err, sa_rst_n, sa_matrix_N, sa_matrix_W, result
    );
`else
    modport master (
        output ld_en, ld_sel, ld_row, ld_col, ld_data, start, sa_matrix_out, sa_valid,
        input  busy, done, sa_rst_n, sa_matrix_N, sa_matrix_W, result
    );
    modport slave (
        input  ld_en, ld_sel, ld_row, ld_col, ld_data, start, sa_matrix_out, sa_valid,
        output busy, done, sa_rst_n, sa_matrix_N, sa_matrix_W, result
    );
`endif
endinterface

// File: rtl/sa_controller.sv
// Sequencer for the systolic-array multiplier: holds A/B, feeds skewed operands, captures result.
// Optional macro SA_CTRL_TIMEOUT_EN enables a DRAIN watchdog and the sticky err flag.
module sa_controller #(
    parameter int N     = 4,
    parameter int WDATA = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sa_controller_if.slave    bus,
    output logic [2:0]        dbg_state
);
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int IW1 = $clog2(N + 1);
    localparam int TW  = $clog2(2 * N);
    localparam int RW  = 2 * WDATA;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                           state_q, state_d;
    logic [TW-1:0]                    t_q, t_d;
    logic                             sa_rst_n_q, sa_rst_n_d;
    logic [1:N][1:N][RW-1:0]          result_q, result_d;
    logic [N-1:0][N-1:0][WDATA-1:0]   a_q, a_d, b_q, b_d;
    logic [1:N][WDATA-1:0]            feed_w, feed_n;
`ifdef SA_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(3 * N + 4);
    logic [WW-1:0]                    wd_q, wd_d;
    logic                             err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
`ifdef SA_CTRL_TIMEOUT_EN
        wd_d     = wd_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.ld_en) begin
                    if (bus.ld_sel) b_d[bus.ld_row][bus.ld_col] = bus.ld_data;
                    else            a_d[bus.ld_row][bus.ld_col] = bus.ld_data;
                end
                if (bus.start) begin
                    state_d = S_CLEAR;
`ifdef SA_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                if (t_q == TW'(2 * N - 2)) begin
                    state_d = S_DRAIN;
`ifdef SA_CTRL_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (bus.sa_valid) begin
                    result_d = bus.sa_matrix_out;
                    state_d  = S_DONE;
                end
`ifdef SA_CTRL_TIMEOUT_EN
                else if (wd_q == WW'(3 * N + 3)) begin
                    // Give up on the array: finish the run without touching result.
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        sa_rst_n_d = (state_d != S_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            sa_rst_n_q <= 1'b0;
            result_q   <= '0;
`ifdef SA_CTRL_TIMEOUT_EN
            wd_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            sa_rst_n_q <= sa_rst_n_d;
            result_q   <= result_d;
`ifdef SA_CTRL_TIMEOUT_EN
            wd_q       <= wd_d;
            err_q      <= err_d;
`endif
        end
    end

    // Operand storage deliberately has no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    // Skew: row i / column j (0-based here) sees element k = t - i, zero outside the window.
    always_comb begin
        int k;
        k      = 0;
        feed_w = '0;
        feed_n = '0;
        if (state_q == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                k = int'(t_q) - i;
                if (k >= 0 && k < N) begin
                    feed_w[IW1'(i + 1)] = a_q[IW'(i)][k[IW-1:0]];
                    feed_n[IW1'(i + 1)] = b_q[k[IW-1:0]][IW'(i)];
                end
            end
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.sa_rst_n    = sa_rst_n_q;
    assign bus.sa_matrix_W = feed_w;
    assign bus.sa_matrix_N = feed_n;
    assign bus.result      = result_q;
`ifdef SA_CTRL_TIMEOUT_EN
    assign bus.err         = err_q;
`endif
    assign dbg_state       = state_q;
endmodule
